logistic_bank: RTL
==================

Name: logistic_bank

Overview:
- Parametrised multi-channel logistic-map engine: iterates x(n+1) = mu*x(n)*(1-x(n)) on N_CH channels for a programmable number of steps.
- Channels are time-multiplexed over one shared W x (W+2) multiplier.
- Sits between the control/keypad logic, which supplies mu, seed and step count, and the VGA pixel-colour logic, which reads per-channel results through a registered read port.
- Replaces per-channel combinational iterators with a start/busy/done handshake.

Parameters:
- W, 16, fractional width of x (Q0.W, range [0,1)); mu is Q2.W (W+2 bits).
- N_CH, 8, number of channels (1..64).
- CW, 9, width of the iteration-count input.
- AW, $clog2(N_CH) (min 1), width of the channel index.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous reset, active-high.
- start  in  1  request a run; sampled only when busy=0.
- mu  in  W+2  Q2.W gain, latched on accepted start.
- seed  in  W  initial x of channel 0, latched on accepted start.
- seed_step  in  W  seed increment per channel, latched.
- times  in  CW  iterations per channel, latched.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- rd_ch  in  AW  channel select for readout.
- rd_data  out  W  registered x[rd_ch].
- iter  out  CW  completed iterations of the current/last run.

Behaviour:
- Reset (RST=1 at posedge): state IDLE; busy=0, done=0, iter=0, rd_data=0, all x[k]=0, latched mu/times=0. Reset overrides any run in progress, with no partial done.
- FSM states: IDLE, LOAD, MUL_A, MUL_B, FIN.
- IDLE: start=1 at edge e -> latch mu, seed, seed_step, times; busy=1 and state=LOAD after e. start while busy=1 is ignored; it is not queued.
- LOAD (1 cycle): x[k] <= seed + k*seed_step, mod 2^W, for all k; ch=0; iter=0. If times==0, go to FIN; otherwise go to MUL_A.
- MUL_A: t <= (x[ch] * (2^W - x[ch])) >> W. Width: W-bit x times (W+1)-bit (1-x) gives a 2W+1-bit product, truncated to W bits after the shift; max value 2^(W-2).
- MUL_B: p = mu * t, a (2W+2)-bit product; y = p >> W, saturated to 2^W-1 if any bit at or above W is set. x[ch] <= y. Then:
  - ch < N_CH-1: ch++ and return to MUL_A.
  - else: ch=0 and iter++. If iter+1 == latched times, go to FIN; otherwise go to MUL_A.
- FIN: done=1 for exactly one cycle; busy=0 in the same cycle; then IDLE. iter holds its final value until the next LOAD.
- Latency: start accepted at edge e gives done high after edge e+2+2*N_CH*times, and low one edge later.
- Channel order: every channel completes iteration n before any channel starts n+1.
- Readout:
  - rd_data <= x[rd_ch] every cycle (1-cycle latency), independent of state.
  - Reads during busy return in-progress values.
  - rd_ch >= N_CH returns 0.
- Inputs mu/seed/times may change freely while busy; only latched copies are used.
- start high in the same cycle as done (FIN): ignored. start is next sampled in IDLE.
- Exactly one multiplier instance.

Test Plan:
- Defaults (W=16, N_CH=8). mu=0x20000 (2.0), seed=0x8000, seed_step=0, times=5 -> after done, all rd_data=0x8000 (fixed point).
- mu=0x30000 (3.0), seed=0x4000, step=0, times=1 -> rd_data=0x9000 for all channels. times=2 -> 0xBD00; check against a bit-exact reference model.
- Saturation/edge: mu=0x3FFFF, seed=0x8000, times=1 -> 0xFFFF. mu=0 with any seed -> 0x0000. seed=0, mu=0x3FFFF, times=100 -> remains 0.
- Latency/handshake: times=3, start pulse at edge e -> busy rises after e; done pulses exactly after edge e+50; iter=3. A second start at e+10 is ignored (done timing unchanged). times=0 -> done after e+2, rd_data[k] = seed + k*seed_step (e.g. seed=0xFFF0, step=0x0008: ch2 = 0x0000, wrap).
- Reset mid-run: RST=1 at e+20 -> busy=0, done never pulses, rd_data=0 one cycle later, iter=0. A fresh start then completes normally.
- Randomised mu/seed/step/times (times <= 20) vs. software model, checking every channel via rd_ch sweep; rd_ch=8..? returns 0 only when N_CH < 2^AW (run also with N_CH=5).

Source files
------------

// File: rtl/logistic_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logistic_bank: N_CH logistic-map iterators x <- mu*x*(1-x) sharing one     |
// | multiplier, with a start/busy/done handshake and a registered read port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module logistic_bank #(
   parameter int W    = 16,
   parameter int N_CH = 8,
   parameter int CW   = 9,
   parameter int AW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [W+1:0]  mu,
   input  logic [W-1:0]  seed,
   input  logic [W-1:0]  seed_step,
   input  logic [CW-1:0] times,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] rd_ch,
   output logic [W-1:0]  rd_data,
   output logic [CW-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MUL_A = 3'd2,
      S_MUL_B = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam int            PW      = 2 * W + 3;
   localparam logic [AW-1:0] LAST_CH = AW'(N_CH - 1);

   state_t        state_q, state_d;
   logic [W+1:0]  mu_q, mu_d;
   logic [W-1:0]  seed_q, seed_d;
   logic [W-1:0]  step_q, step_d;
   logic [CW-1:0] times_q, times_d;
   logic [CW-1:0] iter_q, iter_d;
   logic [AW-1:0] ch_q, ch_d;
   logic [W-1:0]  t_q, t_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  rd_data_q, rd_data_d;
   logic [W-1:0]  x_q [N_CH];
   logic [W-1:0]  x_d [N_CH];

   logic [W-1:0]  x_cur;
   logic [W+1:0]  mul_a;
   logic [W:0]    mul_b;
   logic [W+2:0]  prod_hi;
   logic [W-1:0]  y_sat;
   logic [W-1:0]  seed_acc;

   always_comb begin
      x_cur = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch_q == AW'(k)) x_cur = x_q[k];
      end
   end

   // The single multiplier: x*(1-x) in MUL_A, mu*t in MUL_B.
   always_comb begin
      if (state_q == S_MUL_B) begin
         mul_a = mu_q;
         mul_b = {1'b0, t_q};
      end else begin
         mul_a = {2'b00, x_cur};
         mul_b = {1'b1, {W{1'b0}}} - {1'b0, x_cur};
      end
   end

   assign prod_hi = (W+3)'((PW'(mul_a) * PW'(mul_b)) >> W);
   assign y_sat   = (|prod_hi[W+2:W]) ? {W{1'b1}} : prod_hi[W-1:0];

   always_comb begin
      state_d  = state_q;
      mu_d     = mu_q;
      seed_d   = seed_q;
      step_d   = step_q;
      times_d  = times_q;
      iter_d   = iter_q;
      ch_d     = ch_q;
      t_d      = t_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      seed_acc = seed_q;
      for (int k = 0; k < N_CH; k++) x_d[k] = x_q[k];

      case (state_q)
         S_IDLE: begin
            // done_q high means FIN just retired; a start in that cycle is dropped.
            if (start && !done_q) begin
               mu_d    = mu;
               seed_d  = seed;
               step_d  = seed_step;
               times_d = times;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            for (int k = 0; k < N_CH; k++) begin
               x_d[k]   = seed_acc;
               seed_acc = seed_acc + step_q;
            end
            ch_d    = '0;
            iter_d  = '0;
            state_d = (times_q == '0) ? S_FIN : S_MUL_A;
         end
         S_MUL_A: begin
            t_d     = prod_hi[W-1:0];
            state_d = S_MUL_B;
         end
         S_MUL_B: begin
            for (int k = 0; k < N_CH; k++) begin
               if (ch_q == AW'(k)) x_d[k] = y_sat;
            end
            if (ch_q == LAST_CH) begin
               ch_d    = '0;
               iter_d  = iter_q + CW'(1);
               state_d = (iter_q + CW'(1) == times_q) ? S_FIN : S_MUL_A;
            end else begin
               ch_d    = ch_q + AW'(1);
               state_d = S_MUL_A;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_data_d = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (rd_ch == AW'(k)) rd_data_d = x_q[k];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         mu_q      <= '0;
         seed_q    <= '0;
         step_q    <= '0;
         times_q   <= '0;
         iter_q    <= '0;
         ch_q      <= '0;
         t_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_data_q <= '0;
         for (int k = 0; k < N_CH; k++) x_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         mu_q      <= mu_d;
         seed_q    <= seed_d;
         step_q    <= step_d;
         times_q   <= times_d;
         iter_q    <= iter_d;
         ch_q      <= ch_d;
         t_q       <= t_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
         for (int k = 0; k < N_CH; k++) x_q[k] <= x_d[k];
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
   assign iter    = iter_q;

endmodule
`default_nettype wire
